// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter
//
// Converts a BIN_W-bit binary value into DIGITS packed BCD digits, one bit per
// ADD/SHIFT cycle pair, and reports overflow and a leading-zero blank mask.
//
// Ports:
//   iClk    clock, rising edge
//   iRst_n  asynchronous active-low reset
//   iStart  conversion request, accepted only while oReady=1
//   iBin    binary value, sampled on the accepting edge
//   oReady  1 while idle
//   oBusy   1 while a conversion is in flight
//   oValid  one-cycle pulse when oBcd/oBlank/oOvf are updated
//   oBcd    result, digit k at [4k+3:4k], held until the next oValid
//   oBlank  bit k=1 when digit k is a leading zero (bit 0 never set)
//   oOvf    1 when iBin >= 10**DIGITS; oBcd then holds iBin mod 10**DIGITS
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iStart,
  input  logic [BIN_W-1:0]      iBin,
  output logic                  oReady,
  output logic                  oBusy,
  output logic                  oValid,
  output logic [4*DIGITS-1:0]   oBcd,
  output logic [DIGITS-1:0]     oBlank,
  output logic                  oOvf
);

  localparam int                BCD_W     = 4 * DIGITS;
  localparam int                CNT_W     = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BIN_W - 1);
  // All digits but the units blanked: a zero result still shows "0".
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [BCD_W-1:0]  bcd;
  logic [BIN_W-1:0]  bin;
  logic              carry;
  logic [CNT_W-1:0]  cnt;

  logic [BCD_W-1:0]  bcdAdj;
  logic [DIGITS-1:0] blankNext;
  logic              allZero;

  // Add-3 correction: each digit independently, no inter-digit carry, so that
  // the following left shift turns any digit >= 5 into a proper decimal carry.
  always_comb begin
    bcdAdj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        bcdAdj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while everything seen so
  // far is zero. Digit 0 is excluded so the units digit is always shown.
  always_comb begin
    blankNext = '0;
    allZero   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      allZero      = allZero & (bcd[4*k +: 4] == 4'd0);
      blankNext[k] = allZero;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= IDLE;
      bcd    <= '0;
      bin    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      oBcd   <= '0;
      oBlank <= BLANK_RST;
      oOvf   <= 1'b0;
      oValid <= 1'b0;
      oReady <= 1'b1;
      oBusy  <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            bcd    <= '0;
            bin    <= iBin;
            carry  <= 1'b0;
            cnt    <= '0;
            state  <= ADD;
            oReady <= 1'b0;
            oBusy  <= 1'b1;
          end
        end
        ADD: begin
          bcd   <= bcdAdj;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd, bin} << 1;
          // Anything leaving the top digit means the value reached 10**DIGITS.
          carry <= carry | bcd[BCD_W-1];
          cnt   <= cnt + CNT_W'(1);
          state <= (cnt == LAST_CNT) ? DONE : ADD;
        end
        DONE: begin
          oBcd   <= bcd;
          oOvf   <= carry;
          oBlank <= blankNext;
          oValid <= 1'b1;
          state  <= IDLE;
          oReady <= 1'b1;
          oBusy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          oReady <= 1'b1;
          oBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0: 14/5, 1: 14/4, 2: 16/5, 3: 1/1
  logic        startA, startB, startC, startD;
  logic [13:0] binA, binB;
  logic [15:0] binC;
  logic [0:0]  binD;
  logic        readyA, readyB, readyC, readyD;
  logic        busyA, busyB, busyC, busyD;
  logic        validA, validB, validC, validD;
  logic [19:0] bcdA, bcdC;
  logic [15:0] bcdB;
  logic [3:0]  bcdD;
  logic [4:0]  blankA, blankC;
  logic [3:0]  blankB;
  logic [0:0]  blankD;
  logic        ovfA, ovfB, ovfC, ovfD;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(5)) uA (
    .iClk(clk), .iRst_n(rst_n), .iStart(startA), .iBin(binA), .oReady(readyA), .oBusy(busyA),
    .oValid(validA), .oBcd(bcdA), .oBlank(blankA), .oOvf(ovfA));
  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) uB (
    .iClk(clk), .iRst_n(rst_n), .iStart(startB), .iBin(binB), .oReady(readyB), .oBusy(busyB),
    .oValid(validB), .oBcd(bcdB), .oBlank(blankB), .oOvf(ovfB));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) uC (
    .iClk(clk), .iRst_n(rst_n), .iStart(startC), .iBin(binC), .oReady(readyC), .oBusy(busyC),
    .oValid(validC), .oBcd(bcdC), .oBlank(blankC), .oOvf(ovfC));
  bin_to_bcd_seq #(.BIN_W(1), .DIGITS(1)) uD (
    .iClk(clk), .iRst_n(rst_n), .iStart(startD), .iBin(binD), .oReady(readyD), .oBusy(busyD),
    .oValid(validD), .oBcd(bcdD), .oBlank(blankD), .oOvf(ovfD));

  function automatic int binW(input int w);
    case (w)
      0, 1:    return 14;
      2:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int digitsOf(input int w);
    case (w)
      0, 2:    return 5;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: plain decimal arithmetic on the value.
  function automatic void model(input int d, input int unsigned v, output logic [19:0] bcd,
                                output logic [4:0] blank, output logic ovf);
    int unsigned p = 1;
    int unsigned m;
    int unsigned pk = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    ovf   = (v >= p);
    m     = v % p;
    bcd   = '0;
    blank = '0;
    for (int k = 0; k < d; k++) begin
      bcd[4*k +: 4] = 4'((m / pk) % 10);
      if (k > 0) blank[k] = (m < pk);
      pk = pk * 10;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setIn(input int w, input logic s, input int unsigned v);
    case (w)
      0: begin startA = s; binA = v[13:0]; end
      1: begin startB = s; binB = v[13:0]; end
      2: begin startC = s; binC = v[15:0]; end
      default: begin startD = s; binD = v[0:0]; end
    endcase
  endtask

  task automatic getOut(input int w, output logic valid, output logic [19:0] bcd,
                        output logic [4:0] blank, output logic ovf, output logic ready,
                        output logic busy);
    case (w)
      0: begin valid = validA; bcd = bcdA; blank = blankA; ovf = ovfA; ready = readyA; busy = busyA; end
      1: begin valid = validB; bcd = {4'b0, bcdB}; blank = {1'b0, blankB}; ovf = ovfB; ready = readyB; busy = busyB; end
      2: begin valid = validC; bcd = bcdC; blank = blankC; ovf = ovfC; ready = readyC; busy = busyC; end
      default: begin valid = validD; bcd = {16'b0, bcdD}; blank = {4'b0, blankD}; ovf = ovfD; ready = readyD; busy = busyD; end
    endcase
  endtask

  // Starts one conversion and waits (bounded) for oValid; lat=-1 on timeout.
  task automatic convert(input int w, input int unsigned v, output logic [19:0] bcd,
                         output logic [4:0] blank, output logic ovf, output int lat);
    logic vld, rdy, bsy;
    setIn(w, 1'b1, v);
    @(posedge clk); #1;
    setIn(w, 1'b0, v);
    lat = -1;
    bcd = '0; blank = '0; ovf = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      getOut(w, vld, bcd, blank, ovf, rdy, bsy);
      if (vld) begin
        lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    int          w;
    int unsigned v;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [19:0] gBcd, eBcd;
    logic [4:0]  gBlank, eBlank;
    logic        gOvf, eOvf, vld, rdy, bsy;
    int          lat;
    int          validCount, validAt, badBusy;
    int          validTimes[$];
    logic [19:0] validBcds[$];
    int unsigned rv;

    vecs[0] = '{0, 0,     20'h00000, 5'b11110, 1'b0};
    vecs[1] = '{0, 16383, 20'h16383, 5'b00000, 1'b0};
    vecs[2] = '{0, 1205,  20'h01205, 5'b10000, 1'b0};
    vecs[3] = '{1, 9999,  20'h09999, 5'b00000, 1'b0};
    vecs[4] = '{1, 10000, 20'h00000, 5'b01110, 1'b1};
    vecs[5] = '{1, 16383, 20'h06383, 5'b00000, 1'b1};
    vecs[6] = '{3, 0,     20'h00000, 5'b00000, 1'b0};
    vecs[7] = '{3, 1,     20'h00001, 5'b00000, 1'b0};
    vecs[8] = '{2, 65535, 20'h65535, 5'b00000, 1'b0};
    vecs[9] = '{0, 7,     20'h00007, 5'b11110, 1'b0};

    setIn(0, 1'b0, 0); setIn(1, 1'b0, 0); setIn(2, 1'b0, 0); setIn(3, 1'b0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    getOut(0, vld, gBcd, gBlank, gOvf, rdy, bsy);
    check("rst_bcd", 32'(gBcd), 32'h0);
    check("rst_blank", 32'(gBlank), 32'b11110);
    check("rst_ovf", 32'(gOvf), 32'h0);
    check("rst_valid", 32'(vld), 32'h0);
    check("rst_ready", 32'(rdy), 32'h1);
    check("rst_busy", 32'(bsy), 32'h0);
    getOut(3, vld, gBcd, gBlank, gOvf, rdy, bsy);
    check("rst_blank_1digit", 32'(gBlank), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].w, vecs[i].v, gBcd, gBlank, gOvf, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(2 * binW(vecs[i].w) + 1));
      check($sformatf("vec%0d_bcd", i), 32'(gBcd), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_blank", i), 32'(gBlank), 32'(vecs[i].blank));
      check($sformatf("vec%0d_ovf", i), 32'(gOvf), 32'(vecs[i].ovf));
    end

    // Randomised against the decimal model
    for (int w = 0; w < 4; w++) begin
      for (int n = 0; n < 20; n++) begin
        rv = $urandom_range(0, (1 << binW(w)) - 1);
        model(digitsOf(w), rv, eBcd, eBlank, eOvf);
        convert(w, rv, gBcd, gBlank, gOvf, lat);
        check($sformatf("rnd_w%0d_v%0d_lat", w, rv), 32'(lat), 32'(2 * binW(w) + 1));
        check($sformatf("rnd_w%0d_v%0d_bcd", w, rv), 32'(gBcd), 32'(eBcd));
        check($sformatf("rnd_w%0d_v%0d_blank", w, rv), 32'(gBlank), 32'(eBlank));
        check($sformatf("rnd_w%0d_v%0d_ovf", w, rv), 32'(gOvf), 32'(eOvf));
      end
    end

    // Start ignored while busy, iBin changes ignored
    setIn(0, 1'b1, 42);
    @(posedge clk); #1;
    setIn(0, 1'b0, 42);
    validCount = 0; validAt = -1; badBusy = 0;
    for (int c = 0; c <= 70; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      getOut(0, vld, gBcd, gBlank, gOvf, rdy, bsy);
      if (c <= 28 && (bsy !== 1'b1 || rdy !== 1'b0)) badBusy++;
      if (c >= 29 && (bsy !== 1'b0 || rdy !== 1'b1)) badBusy++;
      if (vld) begin
        validCount++;
        validAt = c;
        eBcd = gBcd;
      end
      if (c == 5) setIn(0, 1'b1, 777);
      if (c == 6) setIn(0, 1'b0, 1234);
    end
    check("busy_ignore_count", 32'(validCount), 32'd1);
    check("busy_ignore_at", 32'(validAt), 32'd29);
    check("busy_ignore_bcd", 32'(eBcd), 32'h00042);
    check("busy_ready_window", 32'(badBusy), 32'd0);
    getOut(0, vld, gBcd, gBlank, gOvf, rdy, bsy);
    check("bcd_held", 32'(gBcd), 32'h00042);

    // Back-to-back with iStart held high (16-bit instance)
    setIn(2, 1'b1, 123);
    @(posedge clk); #1;
    setIn(2, 1'b1, 45678);
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      getOut(2, vld, gBcd, gBlank, gOvf, rdy, bsy);
      if (vld) begin
        validTimes.push_back(c);
        validBcds.push_back(gBcd);
        if (validTimes.size() == 2) setIn(2, 1'b0, 0);
      end
    end
    check("b2b_count", 32'(validTimes.size()), 32'd2);
    if (validTimes.size() == 2) begin
      check("b2b_first_at", 32'(validTimes[0]), 32'd33);
      check("b2b_spacing", 32'(validTimes[1] - validTimes[0]), 32'd34);
      check("b2b_first_bcd", 32'(validBcds[0]), 32'h00123);
      check("b2b_second_bcd", 32'(validBcds[1]), 32'h45678);
    end

    // Asynchronous reset mid-conversion
    setIn(0, 1'b1, 12345);
    @(posedge clk); #1;
    setIn(0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    getOut(0, vld, gBcd, gBlank, gOvf, rdy, bsy);
    check("arst_bcd", 32'(gBcd), 32'h0);
    check("arst_blank", 32'(gBlank), 32'b11110);
    check("arst_ovf", 32'(gOvf), 32'h0);
    check("arst_valid", 32'(vld), 32'h0);
    check("arst_ready", 32'(rdy), 32'h1);
    check("arst_busy", 32'(bsy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    validCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      getOut(0, vld, gBcd, gBlank, gOvf, rdy, bsy);
      if (vld) validCount++;
    end
    check("arst_no_valid", 32'(validCount), 32'd0);
    convert(0, 99, gBcd, gBlank, gOvf, lat);
    check("arst_after_lat", 32'(lat), 32'd29);
    check("arst_after_bcd", 32'(gBcd), 32'h00099);
    check("arst_after_blank", 32'(gBlank), 32'b11100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
